// File: rtl/axis_vio_burst_driver_if.sv
// AXI-Stream bundle driven by axis_vio_burst_driver.
// The master modport is the stream source; the slave modport is the consuming block.
interface axis_vio_burst_driver_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [DATA_W/8-1:0] tkeep;
    logic                tuser;

    modport master (output tdata, tvalid, tlast, tkeep, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/axis_vio_burst_driver.sv
// VIO-triggered AXI-Stream burst source with status counters and an LED heartbeat.
// Optional watchdog abort on a stalled stream is built when AXIS_DRV_TIMEOUT_EN is defined.
module axis_vio_burst_driver #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int HB_W   = 27,
    parameter int TO_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       burst_len,
    input  logic [DATA_W-1:0]      seed,
    input  logic [DATA_W-1:0]      step,
    input  logic                   mode_inc,
    axis_vio_burst_driver_if.master m_axis,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       beats_sent,
    output logic [15:0]            bursts_done,
    output logic                   timeout_err,
    output logic                   heartbeat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              start_q;
    logic              rise;
    logic              hs;
    logic              last_beat;
    logic              wd_abort;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] step_q;
    logic              mode_q;
    logic [HB_W-1:0]   hb_cnt;

    // A held level must not retrigger, so only the 0->1 transition counts.
    assign rise      = start & ~start_q;
    assign hs        = (state == SEND) & m_axis.tready;
    assign last_beat = (beats_sent == len_q - LEN_W'(1));

    // Stream outputs decode straight from registers, so an async reset clears them at once.
    assign m_axis.tvalid = (state == SEND);
    assign m_axis.tdata  = cur_q;
    assign m_axis.tuser  = m_axis.tvalid & (beats_sent == '0);
    assign m_axis.tlast  = m_axis.tvalid & last_beat;
    assign m_axis.tkeep  = {(DATA_W/8){m_axis.tvalid}};
    assign busy          = (state == SEND);
    assign done          = (state == DONE);
    assign heartbeat     = hb_cnt[HB_W-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = SEND;
            SEND: begin
                if (wd_abort)            state_nxt = IDLE;
                else if (hs && last_beat) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            len_q       <= '0;
            cur_q       <= '0;
            step_q      <= '0;
            mode_q      <= 1'b0;
            beats_sent  <= '0;
            bursts_done <= '0;
            hb_cnt      <= '0;
        end else begin
            start_q <= start;
            hb_cnt  <= hb_cnt + HB_W'(1);
            if (state == IDLE && rise) begin
                len_q      <= (burst_len == '0) ? LEN_W'(1) : burst_len;
                cur_q      <= seed;
                step_q     <= step;
                mode_q     <= mode_inc;
                beats_sent <= '0;
            end
            if (hs) begin
                beats_sent <= beats_sent + LEN_W'(1);
                if (mode_q) cur_q <= cur_q + step_q;
            end
            if (state == DONE) bursts_done <= bursts_done + 16'd1;
        end
    end

`ifdef AXIS_DRV_TIMEOUT_EN
    localparam logic [TO_W-1:0] WD_LIMIT = {TO_W{1'b1}} - TO_W'(1);

    logic [TO_W-1:0] wd_cnt;
    logic            timeout_q;

    // Abort on the stall cycle that carries the count to all-ones.
    assign wd_abort    = (state == SEND) & ~m_axis.tready & (wd_cnt == WD_LIMIT);
    assign timeout_err = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == SEND && !m_axis.tready) wd_cnt <= wd_cnt + TO_W'(1);
            else                                 wd_cnt <= '0;
            if (wd_abort) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_abort    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_vio_burst_driver.sv
// Directed bench for axis_vio_burst_driver: burst data, backpressure, edge detect,
// async reset, heartbeat wrap and (when AXIS_DRV_TIMEOUT_EN is defined) watchdog abort.
module tb_axis_vio_burst_driver;

    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int HB_W   = 4;
    localparam int TO_W   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] step;
    logic              mode_inc;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  beats_sent;
    logic [15:0]       bursts_done;
    logic              timeout_err;
    logic              heartbeat;

    int checks = 0;
    int errors = 0;

    axis_vio_burst_driver_if #(.DATA_W(DATA_W)) m_if ();

    axis_vio_burst_driver #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .HB_W(HB_W), .TO_W(TO_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .burst_len   (burst_len),
        .seed        (seed),
        .step        (step),
        .mode_inc    (mode_inc),
        .m_axis      (m_if),
        .busy        (busy),
        .done        (done),
        .beats_sent  (beats_sent),
        .bursts_done (bursts_done),
        .timeout_err (timeout_err),
        .heartbeat   (heartbeat)
    );

    always #5 clock = ~clock;

    // Sample point: 1 ns after the active edge; inputs changed here land on the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one burst and scores every accepted beat.
    // start_mode 0: one-cycle pulse; 1: held high 100 cycles; 2: toggled during SEND.
    // rmode 0: tready always 1; 1: tready pattern 1,0,0,1,0,0,...
    task automatic run_burst(input int len, input logic [63:0] sd, input logic [63:0] st,
                             input logic inc, input int rmode, input int start_mode,
                             output int beats, output int dones);
        int          exp_len;
        int          done_cyc;
        int          acc_cyc;
        logic [63:0] exp_data;
        logic [63:0] held;
        logic        stalled;
        logic        rdy;
        exp_len   = (len == 0) ? 1 : len;
        burst_len = len[LEN_W-1:0];
        seed      = sd;
        step      = st;
        mode_inc  = inc;
        start     = 1'b1;
        beats     = 0;
        dones     = 0;
        done_cyc  = -1;
        acc_cyc   = -1;
        stalled   = 1'b0;
        held      = '0;
        exp_data  = sd;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            case (start_mode)
                1:       start = (cyc < 100);
                2:       start = (cyc < 6) ? cyc[0] : 1'b0;
                default: start = 1'b0;
            endcase
            if (cyc == 0) begin
                // Changes after the accepted start must not affect the burst.
                seed      = ~sd;
                step      = st + 64'h5;
                burst_len = burst_len + 8'd3;
                mode_inc  = ~inc;
                checks++;
                if (m_if.tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid: got %0b expected 1", m_if.tvalid);
                end
            end
            if (done === 1'b1) begin
                dones++;
                done_cyc = cyc;
                checks++;
                if (acc_cyc + 1 != cyc) begin
                    errors++;
                    $display("FAIL done_timing: done at cycle %0d expected %0d", cyc, acc_cyc + 1);
                end
            end
            rdy = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
            m_if.tready = rdy;
            if (m_if.tvalid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (m_if.tdata !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got %0h expected %0h", m_if.tdata, held);
                    end
                end
                if (beats >= exp_len) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_valid: beat %0d tdata %0h expected no tvalid", beats, m_if.tdata);
                end else if (rdy) begin
                    checks++;
                    if (m_if.tdata !== exp_data || m_if.tuser !== (beats == 0) ||
                        m_if.tlast !== (beats == exp_len - 1) || m_if.tkeep !== 8'hFF) begin
                        errors++;
                        $display("FAIL beat%0d: got data %0h user %0b last %0b keep %0h expected data %0h user %0b last %0b keep ff",
                                 beats, m_if.tdata, m_if.tuser, m_if.tlast, m_if.tkeep,
                                 exp_data, beats == 0, beats == exp_len - 1);
                    end
                end
                if (rdy) begin
                    beats++;
                    acc_cyc = cyc;
                    if (inc) exp_data = exp_data + st;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = m_if.tdata;
                end
            end
            if (dones > 0 && cyc >= done_cyc + 3 && (start_mode != 1 || cyc >= 103)) break;
        end
        start       = 1'b0;
        m_if.tready = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        burst_len   = '0;
        seed        = '0;
        step        = '0;
        mode_inc    = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, busy, done, timeout_err, heartbeat} !== 7'b0 ||
            m_if.tdata !== 64'h0 || m_if.tkeep !== 8'h0 || beats_sent !== 8'h0 || bursts_done !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %0b data %0h busy %0b done %0b beats %0d bursts %0d hb %0b expected all 0",
                     m_if.tvalid, m_if.tdata, busy, done, beats_sent, bursts_done, heartbeat);
        end
        reset = 1'b0;
    endtask

    task automatic test_heartbeat();
        repeat (7) tick();
        checks++;
        if (heartbeat !== 1'b0) begin
            errors++;
            $display("FAIL hb_count7: got %0b expected 0", heartbeat);
        end
        tick();
        checks++;
        if (heartbeat !== 1'b1) begin
            errors++;
            $display("FAIL hb_count8: got %0b expected 1", heartbeat);
        end
        repeat (8) tick();
        checks++;
        if (heartbeat !== 1'b0) begin
            errors++;
            $display("FAIL hb_wrap: got %0b expected 0", heartbeat);
        end
    endtask

    task automatic test_incrementing();
        int beats, dones;
        run_burst(4, 64'h10, 64'h1, 1'b1, 0, 0, beats, dones);
        checks++;
        if (beats != 4 || dones != 1 || beats_sent !== 8'd4 || bursts_done !== 16'd1) begin
            errors++;
            $display("FAIL inc_summary: got beats %0d dones %0d beats_sent %0d bursts %0d expected 4 1 4 1",
                     beats, dones, beats_sent, bursts_done);
        end
    endtask

    task automatic test_backpressure();
        int beats, dones;
        run_burst(4, 64'h10, 64'h1, 1'b1, 1, 0, beats, dones);
        checks++;
        if (beats != 4 || dones != 1 || beats_sent !== 8'd4 || bursts_done !== 16'd2) begin
            errors++;
            $display("FAIL bp_summary: got beats %0d dones %0d beats_sent %0d bursts %0d expected 4 1 4 2",
                     beats, dones, beats_sent, bursts_done);
        end
    endtask

    task automatic test_len_zero();
        int beats, dones;
        run_burst(0, 64'hAA, 64'h7, 1'b0, 0, 0, beats, dones);
        checks++;
        if (beats != 1 || dones != 1 || beats_sent !== 8'd1 || bursts_done !== 16'd3) begin
            errors++;
            $display("FAIL len0_summary: got beats %0d dones %0d beats_sent %0d bursts %0d expected 1 1 1 3",
                     beats, dones, beats_sent, bursts_done);
        end
    endtask

    task automatic test_data_wrap();
        int beats, dones;
        // 0xFF..FE, then 0x1, then 0x4 after modular addition of 3.
        run_burst(3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 1'b1, 0, 0, beats, dones);
        checks++;
        if (beats != 3 || dones != 1 || bursts_done !== 16'd4) begin
            errors++;
            $display("FAIL wrap_summary: got beats %0d dones %0d bursts %0d expected 3 1 4",
                     beats, dones, bursts_done);
        end
    endtask

    task automatic test_start_held();
        int beats, dones;
        run_burst(2, 64'h55, 64'h2, 1'b1, 0, 1, beats, dones);
        checks++;
        if (beats != 2 || dones != 1 || bursts_done !== 16'd5) begin
            errors++;
            $display("FAIL hold_summary: got beats %0d dones %0d bursts %0d expected 2 1 5",
                     beats, dones, bursts_done);
        end
    endtask

    task automatic test_rise_during_send();
        int beats, dones;
        run_burst(3, 64'h100, 64'h10, 1'b1, 1, 2, beats, dones);
        checks++;
        if (beats != 3 || dones != 1 || bursts_done !== 16'd6) begin
            errors++;
            $display("FAIL rise_in_send: got beats %0d dones %0d bursts %0d expected 3 1 6",
                     beats, dones, bursts_done);
        end
    endtask

    task automatic test_reset_mid_burst();
        burst_len   = 8'd8;
        seed        = 64'h200;
        step        = 64'h1;
        mode_inc    = 1'b1;
        start       = 1'b1;
        m_if.tready = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checks++;
        if (beats_sent !== 8'd2 || m_if.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got beats_sent %0d valid %0b expected 2 1", beats_sent, m_if.tvalid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || busy !== 1'b0 || m_if.tdata !== 64'h0 ||
            beats_sent !== 8'h0 || bursts_done !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got valid %0b busy %0b data %0h beats %0d bursts %0d expected all 0",
                     m_if.tvalid, busy, m_if.tdata, beats_sent, bursts_done);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (m_if.tvalid !== 1'b0 || bursts_done !== 16'h0) begin
                errors++;
                $display("FAIL post_reset_idle%0d: got valid %0b bursts %0d expected 0 0",
                         i, m_if.tvalid, bursts_done);
            end
        end
        m_if.tready = 1'b0;
    endtask

`ifdef AXIS_DRV_TIMEOUT_EN
    task automatic test_timeout();
        int dones = 0;
        burst_len   = 8'd4;
        seed        = 64'h300;
        step        = 64'h1;
        mode_inc    = 1'b1;
        m_if.tready = 1'b0;
        start       = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
            if (done === 1'b1) dones++;
            if (k == 15) begin
                checks++;
                if (timeout_err !== 1'b0 || m_if.tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL to_before: got err %0b valid %0b expected 0 1", timeout_err, m_if.tvalid);
                end
            end
            if (k == 16) begin
                checks++;
                if (timeout_err !== 1'b1 || m_if.tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL to_abort: got err %0b valid %0b expected 1 0", timeout_err, m_if.tvalid);
                end
            end
        end
        checks++;
        if (dones != 0 || timeout_err !== 1'b1 || bursts_done !== 16'h0) begin
            errors++;
            $display("FAIL to_final: got dones %0d err %0b bursts %0d expected 0 1 0",
                     dones, timeout_err, bursts_done);
        end
    endtask
`else
    task automatic test_timeout();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_tied: got %0b expected 0", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_heartbeat();
        test_incrementing();
        test_backpressure();
        test_len_zero();
        test_data_wrap();
        test_start_held();
        test_rise_during_send();
        test_reset_mid_burst();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
